// File: rtl/stream_pkg.sv
// Shared encodings for the stream arbiter: FSM states and source ids.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/stream_out_reg.sv
// One-deep registered output stage: captures the granted beat and drives y_*.
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_src,
  input  logic             y_ready,
  output logic             load_en,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_src,
  output logic             y_valid
);

  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;
  logic             y_src_q, y_src_d;
  logic             y_valid_q, y_valid_d;

  always_comb begin
    // Nothing is accepted while reset is held, so no beat can slip past it.
    load_en   = rst_n && (!y_valid_q || y_ready);
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_src_d   = y_src_q;
    if (load_en) begin
      y_valid_d = in_valid;
      if (in_valid) begin
        y_data_d = in_data;
        y_last_d = in_last;
        y_src_d  = in_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_src_q   <= SRC_A;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_src_q   <= y_src_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign y_src   = y_src_q;
  assign y_valid = y_valid_q;

endmodule

// File: rtl/stream_arb_2x1.sv
// Packet-aware two-input round-robin arbiter feeding a registered output stage.
module stream_arb_2x1
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_src,
  output logic             y_valid,
  input  logic             y_ready
);

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   load_en;
  logic   a_acc, b_acc;
  logic   in_valid;
  logic [WIDTH-1:0] in_data;
  logic   in_last;
  logic   in_src;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          if (a_valid && (!b_valid || prio_q == SRC_A)) a_ready = 1'b1;
          else if (b_valid)                             b_ready = 1'b1;
        end
      end
      LOCK_A:  a_ready = load_en;
      LOCK_B:  b_ready = load_en;
      default: ;
    endcase
  end

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    // A packet's last beat releases the lock and hands priority to the other side.
    if (a_acc) begin
      if (a_last) begin
        state_d = IDLE;
        prio_d  = SRC_B;
      end else begin
        state_d = LOCK_A;
      end
    end else if (b_acc) begin
      if (b_last) begin
        state_d = IDLE;
        prio_d  = SRC_A;
      end else begin
        state_d = LOCK_B;
      end
    end else if (state_q != IDLE && state_q != LOCK_A && state_q != LOCK_B) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= SRC_A;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign in_valid = a_acc || b_acc;
  assign in_data  = b_acc ? b_data : a_data;
  assign in_last  = b_acc ? b_last : a_last;
  assign in_src   = b_acc ? SRC_B : SRC_A;

  stream_out_reg #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_last (in_last),
    .in_src  (in_src),
    .y_ready (y_ready),
    .load_en (load_en),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_src   (y_src),
    .y_valid (y_valid)
  );

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Scoreboard bench for stream_arb_2x1: directed packets, hand-written output order.
module tb_stream_arb_2x1;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data, y_data;
  logic       a_last, a_valid, a_ready;
  logic       b_last, b_valid, b_ready;
  logic       y_last, y_src, y_valid, y_ready;

  beat_t aq[$];
  beat_t bq[$];
  beat_t exp_q[$];
  logic  a_hold;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  stream_arb_2x1 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_last(y_last), .y_src(y_src), .y_valid(y_valid),
    .y_ready(y_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t bt(input logic [7:0] d, input logic l, input logic s);
    beat_t r;
    r.d = d; r.l = l; r.s = s;
    return r;
  endfunction

  // Source drivers: present queue heads, retire a beat after its handshake.
  initial begin
    logic a_acc, b_acc;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    forever begin
      @(negedge clk);
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      @(posedge clk);
      #2;
      if (a_acc && aq.size() > 0) void'(aq.pop_front());
      if (b_acc && bq.size() > 0) void'(bq.pop_front());
      a_valid = (aq.size() > 0) && !a_hold;
      if (aq.size() > 0) begin a_data = aq[0].d; a_last = aq[0].l; end
      b_valid = (bq.size() > 0);
      if (bq.size() > 0) begin b_data = bq[0].d; b_last = bq[0].l; end
    end
  end

  // Output monitor: every accepted y beat must match the next expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (y_valid === 1'b1 && y_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("y_unexpected_beat", {y_data, y_last, y_src}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("y_beat", {22'd0, y_data, y_last, y_src}, {22'd0, e.d, e.l, e.s});
        end
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((aq.size() != 0 || bq.size() != 0 || exp_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain", {aq.size() != 0, bq.size() != 0, exp_q.size() != 0}, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; y_ready = 1'b1; a_hold = 1'b0;

    // Reset with both sources valid
    aq.push_back(bt(8'h01, 1'b1, 1'b0));
    bq.push_back(bt(8'h02, 1'b1, 1'b1));
    tick(); tick();
    @(negedge clk);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_src", y_src, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    exp_q.push_back(bt(8'h01, 1'b1, 1'b0));
    exp_q.push_back(bt(8'h02, 1'b1, 1'b1));
    tick();
    rst_n = 1'b1;
    wait_drain();

    // Alternating single-beat packets
    for (int i = 0; i < 4; i++) begin
      aq.push_back(bt(8'h11, 1'b1, 1'b0));
      bq.push_back(bt(8'h22, 1'b1, 1'b1));
      exp_q.push_back(bt(8'h11, 1'b1, 1'b0));
      exp_q.push_back(bt(8'h22, 1'b1, 1'b1));
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_y_valid", y_valid, 1);
      tick();
    end
    wait_drain();

    // Packet lock: A 3-beat packet while B waits
    aq.push_back(bt(8'hA0, 1'b0, 1'b0));
    aq.push_back(bt(8'hA1, 1'b0, 1'b0));
    aq.push_back(bt(8'hA2, 1'b1, 1'b0));
    bq.push_back(bt(8'hB0, 1'b1, 1'b1));
    exp_q.push_back(bt(8'hA0, 1'b0, 1'b0));
    exp_q.push_back(bt(8'hA1, 1'b0, 1'b0));
    exp_q.push_back(bt(8'hA2, 1'b1, 1'b0));
    exp_q.push_back(bt(8'hB0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_b_ready_low", b_ready, 0);
    end
    @(negedge clk);
    chk("lock_b_ready_after", b_ready, 1);
    wait_drain();

    // Lock with a two-cycle source bubble
    aq.push_back(bt(8'hC0, 1'b0, 1'b0));
    aq.push_back(bt(8'hC1, 1'b0, 1'b0));
    aq.push_back(bt(8'hC2, 1'b0, 1'b0));
    aq.push_back(bt(8'hC3, 1'b1, 1'b0));
    bq.push_back(bt(8'hD0, 1'b1, 1'b1));
    exp_q.push_back(bt(8'hC0, 1'b0, 1'b0));
    exp_q.push_back(bt(8'hC1, 1'b0, 1'b0));
    exp_q.push_back(bt(8'hC2, 1'b0, 1'b0));
    exp_q.push_back(bt(8'hC3, 1'b1, 1'b0));
    exp_q.push_back(bt(8'hD0, 1'b1, 1'b1));
    tick(); tick();
    a_hold = 1'b1;
    tick();
    @(negedge clk);
    chk("bubble_y_valid_1", y_valid, 0);
    chk("bubble_b_ready", b_ready, 0);
    tick();
    a_hold = 1'b0;
    @(negedge clk);
    chk("bubble_y_valid_2", y_valid, 0);
    chk("bubble_b_ready_2", b_ready, 0);
    wait_drain();

    // Backpressure holds y and the arbiter
    aq.push_back(bt(8'h55, 1'b1, 1'b0));
    aq.push_back(bt(8'h66, 1'b1, 1'b0));
    bq.push_back(bt(8'h77, 1'b1, 1'b1));
    exp_q.push_back(bt(8'h55, 1'b1, 1'b0));
    exp_q.push_back(bt(8'h77, 1'b1, 1'b1));
    exp_q.push_back(bt(8'h66, 1'b1, 1'b0));
    tick();
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_y_valid", y_valid, 1);
      chk("bp_y_data", y_data, 8'h55);
      chk("bp_ready", {a_ready, b_ready}, 0);
    end
    tick();
    y_ready = 1'b1;
    wait_drain();

    // Reset during LOCK_B after one beat
    bq.push_back(bt(8'hE0, 1'b0, 1'b1));
    bq.push_back(bt(8'hE1, 1'b0, 1'b1));
    bq.push_back(bt(8'hE2, 1'b1, 1'b1));
    exp_q.push_back(bt(8'hE0, 1'b0, 1'b1));
    tick();
    rst_n = 1'b0;
    aq.delete();
    bq.delete();
    tick();
    @(negedge clk);
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_ready", {a_ready, b_ready}, 0);
    tick();
    rst_n = 1'b1;
    aq.push_back(bt(8'h3A, 1'b1, 1'b0));
    bq.push_back(bt(8'h3B, 1'b1, 1'b1));
    exp_q.push_back(bt(8'h3A, 1'b1, 1'b0));
    exp_q.push_back(bt(8'h3B, 1'b1, 1'b1));
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_arb_2x1.md
Name: stream_arb_2x1

Overview:
- Two-input, packet-aware round-robin arbiter with a registered output stage.
- Merges two valid/ready streams (a, b) onto one output stream y.
- Once a packet is granted, it holds the grant until that packet's last beat is accepted.
- Produces the select line (y_src) for the downstream 2:1 selection stage and a 1-cycle-latency, full-throughput output.

Parameters:
WIDTH, 8, data width of a_data, b_data, y_data

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
a_data  input  WIDTH  source A beat data
a_last  input  1  source A end-of-packet flag
a_valid  input  1  source A beat valid
a_ready  output  1  source A beat accepted this cycle when a_valid && a_ready
b_data  input  WIDTH  source B beat data
b_last  input  1  source B end-of-packet flag
b_valid  input  1  source B beat valid
b_ready  output  1  source B beat accepted this cycle when b_valid && b_ready
y_data  output  WIDTH  registered output data
y_last  output  1  registered end-of-packet flag
y_src  output  1  source of current y beat: 0 = A, 1 = B (select line for the downstream mux)
y_valid  output  1  output beat valid
y_ready  input  1  downstream accepts when y_valid && y_ready

Behaviour:
- Reset, sampled on rising clk while rst_n = 0:
  - y_valid = 0, y_data = 0, y_last = 0, y_src = 0.
  - state = IDLE, prio = A.
  - Any packet in flight is dropped; no partial beat survives reset.
- load_en = !y_valid || y_ready. This gives one-deep output register pass-through at full throughput.
- a_ready and b_ready are combinational from state, prio, valids and load_en. They never depend on a_ready/b_ready themselves.
- State machine:
  - IDLE:
    - If load_en and exactly one source is valid, grant that source.
    - If both are valid, grant the prio source.
    - A beat is transferred in the same cycle (no grant bubble).
    - Granted beat with last = 1: stay IDLE; prio <= other source.
    - Granted beat with last = 0: go to LOCK_A or LOCK_B.
  - LOCK_A: a_ready = load_en, b_ready = 0. On accepted A beat with a_last = 1: go to IDLE, prio <= B.
  - LOCK_B: symmetric; on accepted b_last, go to IDLE, prio <= A.
  - In LOCK states, invalid cycles of the locked source are bubbles; the other source waits even if valid.
- Transfer: on an accepted input beat, the next edge loads y_data, y_last and y_src from the granted source and sets y_valid = 1.
- If y_ready && y_valid with no input accepted, the next edge clears y_valid. y_data, y_last and y_src hold their last values.
- Backpressure: y_valid && !y_ready. Then load_en = 0, a_ready = b_ready = 0, and y holds stable. The state and prio registers do not change.
- Latency: input accept to y_valid is 1 cycle. Sustained throughput is 1 beat/cycle when y_ready = 1.
- Fairness: with both sources continuously valid, packets alternate A, B, A, B, ...; beats of different packets never interleave.
- Single-beat packets (last = 1 on the first beat) never enter a LOCK state.
- Both ready signals are never high in the same cycle.

Decomposition:
- Shared package stream_pkg:
  - State encoding constants: IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2.
  - Source-id constants: SRC_A = 1'b0, SRC_B = 1'b1.
- One natural sub-module, stream_out_reg:
  - Holds the output register, the y_valid / load_en logic and the data/last/src capture.
  - Parameterised by WIDTH.
- The arbiter FSM and prio pointer stay in the top module.

Test Plan:
- Reset behaviour:
  - Stimulus: hold rst_n = 0 for 2 cycles with a_valid = b_valid = 1.
  - Required: y_valid = 0, y_data = 0, y_src = 0, a_ready = b_ready = 0 while in reset.
  - After release with y_ready = 1: first grant goes to A.
- Alternating single-beat packets:
  - Stimulus: a = 0x11 (last = 1) and b = 0x22 (last = 1), both continuously valid, y_ready = 1.
  - Required: y sequence 0x11 / src 0, 0x22 / src 1, 0x11, 0x22 ..., y_valid = 1 every cycle from cycle 1.
- Packet lock:
  - Stimulus: A sends a 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2); B is valid with 0xB0 (last = 1) throughout.
  - Required: b_ready = 0 until 0xA2 is accepted.
  - Output order: 0xA0, 0xA1, 0xA2, 0xB0.
- Lock with source bubble:
  - Stimulus: A deasserts a_valid for 2 cycles mid-packet while b_valid = 1.
  - Required: no B beat appears; y_valid drops for 2 cycles; the A packet completes contiguously.
- Backpressure:
  - Stimulus: y_ready = 0 for 3 cycles while y holds 0x55.
  - Required: y_data = 0x55 stable, a_ready = b_ready = 0, state unchanged.
  - On y_ready = 1: next beat appears on the following cycle with no loss or duplication.
- Reset mid-packet:
  - Stimulus: assert rst_n = 0 during LOCK_B after 1 of 3 beats.
  - Required: y_valid = 0 next cycle, state = IDLE, prio = A.
  - After reset, a fresh A packet is granted first.
